// File: rtl/dp_ram_arbiter.sv
// Round-robin arbiter sharing the two ports of an async-read dual-port RAM among NUM_REQ requesters.
// Optional conflict counter port enabled with `define DP_RAM_ARB_STATS_EN.
module dp_ram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 1000,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_rdata,
  output logic                             we_a,
  output logic [ADDR_WIDTH-1:0]            addr_a,
  output logic [DATA_WIDTH-1:0]            din_a,
  input  logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             we_b,
  output logic [ADDR_WIDTH-1:0]            addr_b,
  output logic [DATA_WIDTH-1:0]            din_b,
  input  logic [DATA_WIDTH-1:0]            dout_b
`ifdef DP_RAM_ARB_STATS_EN
  ,
  output logic [15:0]                      conflict_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]              r_ptr;
  logic [NUM_REQ-1:0]            r_rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_rdata;

  logic [ADDR_WIDTH-1:0]         w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]         w_wdata [NUM_REQ];
  logic                          w_a_found;
  logic                          w_b_found;
  logic [PTR_W-1:0]              w_a_idx;
  logic [PTR_W-1:0]              w_b_idx;
  logic [PTR_W-1:0]              w_scan_idx;
  logic                          w_conflict;
  logic                          w_grant_a;
  logic                          w_grant_b;
  logic [NUM_REQ-1:0]            w_ready;
  logic [NUM_REQ-1:0]            w_sel_b;

  // (base + k) mod NUM_REQ, with k < NUM_REQ so one subtraction suffices
  function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
    return s[PTR_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from the pointer for the first two valid requesters
  always_comb begin
    w_a_found  = 1'b0;
    w_b_found  = 1'b0;
    w_a_idx    = '0;
    w_b_idx    = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = rr_idx(r_ptr, k);
      if (req_valid[w_scan_idx] && !w_a_found) begin
        w_a_found = 1'b1;
        w_a_idx   = w_scan_idx;
      end else if (req_valid[w_scan_idx] && !w_b_found) begin
        w_b_found = 1'b1;
        w_b_idx   = w_scan_idx;
      end else begin
        w_b_found = w_b_found;
      end
    end
  end

  // A same-address pair involving a write is never issued on both ports at once;
  // the B candidate simply waits, no further search is made.
  assign w_conflict = w_b_found && (w_addr[w_a_idx] == w_addr[w_b_idx]) &&
                      (req_we[w_a_idx] || req_we[w_b_idx]);
  assign w_grant_a  = rst_n && w_a_found;
  assign w_grant_b  = rst_n && w_b_found && !w_conflict;

  // Grant vector and per-slot port-B select
  always_comb begin
    w_ready = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sel_b[i] = w_grant_b && (w_b_idx == PTR_W'(i));
      w_ready[i] = (w_grant_a && (w_a_idx == PTR_W'(i))) || w_sel_b[i];
    end
  end

  assign req_ready = w_ready;

  // RAM port drive; idle ports present all-zero
  always_comb begin
    we_a   = 1'b0;
    addr_a = '0;
    din_a  = '0;
    we_b   = 1'b0;
    addr_b = '0;
    din_b  = '0;
    if (w_grant_a) begin
      we_a   = req_we[w_a_idx];
      addr_a = w_addr[w_a_idx];
      din_a  = w_wdata[w_a_idx];
    end else begin
      we_a   = 1'b0;
    end
    if (w_grant_b) begin
      we_b   = req_we[w_b_idx];
      addr_b = w_addr[w_b_idx];
      din_b  = w_wdata[w_b_idx];
    end else begin
      we_b   = 1'b0;
    end
  end

  // Round-robin pointer: one past the last granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant_b) begin
      r_ptr <= rr_idx(w_b_idx, 1);
    end else if (w_grant_a) begin
      r_ptr <= rr_idx(w_a_idx, 1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Responses capture the async read data seen at the grant edge (pre-write contents)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_ready;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_ready[i]) begin
          r_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= w_sel_b[i] ? dout_b : dout_a;
        end else begin
          r_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= r_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

`ifdef DP_RAM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of cycles where the B candidate was deferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'h0000;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'h0001;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: doc/dp_ram_arbiter.md
# dp_ram_arbiter

Round-robin arbiter that shares the two ports of `dp_ram_async_read` among `NUM_REQ` requesters. Each cycle it grants up to two requests, one to port A and one to port B. It defers a second request that collides on the same address with a write, and returns read data one cycle after grant. It sits between client engines (DMA, compute units) and a single dual-port buffer instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: RAM word width.
- `MEM_DEPTH`, 1000: RAM depth in words.
- `ADDR_WIDTH`, `$clog2(MEM_DEPTH)`: address width, derived.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i occupies bits [i*AW +: AW].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `req_ready` out NUM_REQ: grant, combinational, one-hot-or-two-hot.
- `rsp_valid` out NUM_REQ: registered, pulses one cycle after grant.
- `rsp_rdata` out NUM_REQ*DATA_WIDTH: registered response data.
- `we_a`, `addr_a`, `din_a` out 1/AW/DW: drive RAM port A.
- `dout_a` in DW: RAM port A async read data.
- `we_b`, `addr_b`, `din_b` out 1/AW/DW: drive RAM port B.
- `dout_b` in DW: RAM port B async read data.
- `conflict_cnt` out 16: present only with `DP_RAM_ARB_STATS_EN`.

## Operation
- **Scan order:** ptr, ptr+1, …, ptr+NUM_REQ-1 (mod NUM_REQ). `ptr` is a registered round-robin pointer.
- **Port A:** the first valid requester in scan order.
- **Port B:** the second valid requester in scan order, subject to the conflict rule.
- **Conflict:** the port-B candidate has `addr == addr_A` and either request is a write.
  - On conflict, port B is idle that cycle; no further search is made.
  - The candidate stays ungranted and keeps `req_valid` asserted.
- **Transfer:** a transaction completes when `req_valid & req_ready` is high at the rising edge. Requesters hold `we`/`addr`/`wdata` stable until granted.
- **Idle port:** `we`=0, `addr`=0, `din`=0.
- **Pointer update:** `ptr_next = (last granted index + 1) mod NUM_REQ`. The last granted index is B's if B was granted, else A's. With no grants, `ptr` holds.
- **Fairness:** a deferred requester is scanned first or second in the next cycle, so every asserted request is granted within NUM_REQ cycles.
- **Responses:**
  - Each granted requester i sees `rsp_valid[i]`=1 in the next cycle.
  - `rsp_rdata[i]` is captured from the granting port's `dout` at the grant edge.
  - Reads return the stored word. Writes return the word's prior contents (read-before-write).
  - Non-granted slots hold `rsp_rdata`; their `rsp_valid` is 0.
- **Back-to-back:** a requester may be re-granted in consecutive cycles. A read immediately after a granted write to the same address returns the new data.

## Timing
- **Reset:** while `rst_n`=0:
  - `ptr`=0, `rsp_valid`=0, `rsp_rdata`=0, `conflict_cnt`=0.
  - `req_ready`=0, `we_a`=`we_b`=0.
- **Reset release:** arbitration begins on the first rising edge after release.
- **Reset mid-operation:** any in-flight response pulse is dropped and no RAM write is issued in the reset cycle.
- **Grant latency:** 0 cycles; `req_ready` is combinational from `req_valid`, `req_we`, `req_addr` and `ptr`.
- **Response latency:** exactly 1 cycle after grant; throughput is up to 2 transactions per cycle.
- **Single requester:** always granted on port A; port B is idle.
- **Pointer wrap:** from NUM_REQ-1, `ptr` wraps to 0.

## Configuration
- **`DP_RAM_ARB_STATS_EN` defined:**
  - `conflict_cnt` port exists.
  - Increments by 1 every cycle a port-B candidate is deferred by the conflict rule.
  - Saturates at 16'hFFFF; reset to 0.
- **Undefined:** port and counter are absent; arbitration behaviour is identical.

## Test plan
- **Reset:** `rst_n` low with all `req_valid`=1 -> `req_ready`=0, `we_a`=`we_b`=0, `rsp_valid`=0; after release, requesters 0 and 1 are granted first.
- **Dual write then read:**
  - Cycle 1: req0 writes 8'hAA @0x01, req1 writes 8'hBB @0x02 -> both granted, A=req0, B=req1.
  - Next cycle: same requesters read the same addresses -> responses AA and BB one cycle after grant.
- **Write/write conflict:** req0 and req1 both write @0x03 (8'h11, 8'h22) -> req0 is granted; req1 is granted next cycle; a subsequent read @0x03 returns 8'h22; `conflict_cnt`=1 when enabled.
- **Read/read same address:** req2 and req3 read @0x01 -> both granted in the same cycle; both return AA; no conflict counted.
- **Fairness:** all 4 requesters hold read requests for 8 cycles -> grant pairs (0,1),(2,3),(0,1),(2,3); no requester waits more than 2 cycles.
- **Write rsp data:** write 8'h55 @0x01 after AA was stored -> `rsp_rdata`=AA for the write; a following read returns 55.
